// File: rtl/enc_binder_seq_if.sv
// enc_binder_seq_if
// Bundles the frame-control, input-batch and output-batch signals of
// enc_binder_seq into a single interface.
//
// Signals:
//   start_encoding  opens a frame (one-cycle pulse)
//   in_valid        level_hv holds a valid batch
//   in_ready        binder accepts a batch this cycle
//   level_hv        per-lane level hypervectors
//   shifted_hv      per-lane registered bound hypervectors
//   out_valid       shifted_hv holds a valid batch
//   out_ready       downstream consumes shifted_hv
//   batch_idx       batch number of the current shifted_hv
//   busy            frame in progress
//   done            one-cycle pulse when the last batch of a frame is consumed
//   bundle_hv       OR-bundle of the whole frame (zero when bundling is off)
//
// Modports:
//   master  drives the frame and input batches and consumes the outputs (producer/consumer side)
//   slave   the binder itself
interface enc_binder_seq_if #(
    parameter int HV_DIM      = 1024,
    parameter int LANES       = 8,
    parameter int NUM_BATCHES = 4
);
    localparam int BW = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;

    logic              start_encoding;
    logic              in_valid;
    logic              in_ready;
    logic [HV_DIM-1:0] level_hv   [LANES];
    logic [HV_DIM-1:0] shifted_hv [LANES];
    logic              out_valid;
    logic              out_ready;
    logic [BW-1:0]     batch_idx;
    logic              busy;
    logic              done;
    logic [HV_DIM-1:0] bundle_hv;

    modport master (
        output start_encoding, in_valid, level_hv, out_ready,
        input  in_ready, shifted_hv, out_valid, batch_idx, busy, done, bundle_hv
    );

    modport slave (
        input  start_encoding, in_valid, level_hv, out_ready,
        output in_ready, shifted_hv, out_valid, batch_idx, busy, done, bundle_hv
    );
endinterface

// File: rtl/enc_binder_seq.sv
// enc_binder_seq
// Sequential hypervector binder. A frame is opened by start_encoding and
// consists of NUM_BATCHES batches of LANES level hypervectors each. Every
// accepted lane is rotated left by an entry of the SHIFTS table (selected by
// BASE_IDX, batch number and lane) and registered to shifted_hv with a
// valid/ready handshake on both sides.
//
// Ports:
//   clk   single clock, rising edge
//   nrst  asynchronous active-low reset
//   bus   enc_binder_seq_if.slave (handshake, data and status signals)
//
// Build option:
//   ENC_BIND_BUNDLE_EN  when defined, bundle_hv OR-accumulates every bound
//                       lane of the frame; otherwise bundle_hv is tied to 0
//                       and no accumulator is built.

package enc_binder_pkg;
    localparam int SHIFTS_LEN = 64;
    localparam int SHIFTS_IW  = $clog2(SHIFTS_LEN);

    // Rotation amounts per feature; amounts are taken modulo HV_DIM.
    localparam int SHIFTS [SHIFTS_LEN] = '{
        1,   0,   15,  16,   3,   7,   11,  29,   42,  5,   63,  100,  17,  256, 9,   31,
        512, 77,  2,   1023, 48,  13,  200, 6,    91,  384, 27,  640,  8,   333, 55,  19,
        700, 4,   128, 61,   999, 22,  450, 37,   12,  811, 73,  160,  29,  555, 10,  900,
        66,  241, 18,  1000, 35,  470, 14,  777,  88,  306, 21,  64,   590, 44,  123, 1010
    };
endpackage

module enc_binder_seq #(
    parameter int HV_DIM      = 1024,
    parameter int LANES       = 8,
    parameter int NUM_BATCHES = 4,
    parameter int BASE_IDX    = 0
) (
    input  logic              clk,
    input  logic              nrst,
    enc_binder_seq_if.slave   bus
);
    localparam int BW = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam int IW = enc_binder_pkg::SHIFTS_IW;

    typedef enum logic [1:0] {IDLE, BIND, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     batch_idx_q, batch_idx_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic [HV_DIM-1:0] shifted_q [LANES];
    logic [HV_DIM-1:0] shifted_d [LANES];
    logic [HV_DIM-1:0] bound     [LANES];

    logic in_ready;
    logic accept;
    logic consume;

    // The table index is truncated to the table size, so an out-of-range
    // BASE_IDX/LANES/NUM_BATCHES combination wraps instead of reading garbage.
    function automatic int shift_amt(input int lane, input logic [BW-1:0] batch);
        logic [IW-1:0] idx;
        idx = IW'(BASE_IDX + int'(batch) * LANES + lane);
        return enc_binder_pkg::SHIFTS[idx] % HV_DIM;
    endfunction

    // A shift of HV_DIM on the right-hand term yields zero, so amt == 0
    // passes the vector through unchanged.
    function automatic logic [HV_DIM-1:0] rotl(input logic [HV_DIM-1:0] v, input int amt);
        return (v << amt) | (v >> (HV_DIM - amt));
    endfunction

    assign in_ready = (state_q == BIND) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = out_valid_q && bus.out_ready;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            bound[i] = rotl(bus.level_hv[i], shift_amt(i, cnt_q));
        end
    end

    // Accepting while the previous batch is consumed keeps out_valid high,
    // which gives one batch per cycle under no backpressure.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        batch_idx_d = batch_idx_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        shifted_d   = shifted_q;

        case (state_q)
            IDLE: begin
                if (bus.start_encoding) begin
                    state_d = BIND;
                    cnt_d   = '0;
                end
            end
            BIND: begin
                if (accept && (cnt_q == BW'(NUM_BATCHES - 1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (consume) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            cnt_d       = cnt_q + 1'b1;
            batch_idx_d = cnt_q;
            out_valid_d = 1'b1;
            shifted_d   = bound;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            batch_idx_q <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                shifted_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            batch_idx_q <= batch_idx_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            shifted_q   <= shifted_d;
        end
    end

`ifdef ENC_BIND_BUNDLE_EN
    logic [HV_DIM-1:0] bundle_q, bundle_d;

    // Cleared only by a start that actually opens a frame, so the bundle
    // stays readable after done until the next frame begins.
    always_comb begin
        bundle_d = bundle_q;
        if ((state_q == IDLE) && bus.start_encoding) begin
            bundle_d = '0;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                bundle_d = bundle_d | bound[i];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bundle_q <= '0;
        end else begin
            bundle_q <= bundle_d;
        end
    end

    assign bus.bundle_hv = bundle_q;
`else
    assign bus.bundle_hv = '0;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign bus.shifted_hv[g] = shifted_q[g];
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.batch_idx = batch_idx_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_enc_binder_seq.sv
// tb_enc_binder_seq
// Self-checking bench for enc_binder_seq (HV_DIM=16, LANES=2, NUM_BATCHES=2).
// A transaction-level reference model (frame open flag, accept count,
// pending output, bundle) predicts every output each cycle.
module tb_enc_binder_seq;
    localparam int HV = 16;
    localparam int LN = 2;
    localparam int NB = 2;

    logic clk  = 1'b0;
    logic nrst = 1'b1;

    always #5 clk = ~clk;

    enc_binder_seq_if #(.HV_DIM(HV), .LANES(LN), .NUM_BATCHES(NB)) bus ();

    enc_binder_seq #(
        .HV_DIM(HV), .LANES(LN), .NUM_BATCHES(NB), .BASE_IDX(0)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int shifts_ref [LN*NB] = '{1, 0, 15, 16};

    // Reference model state
    bit          m_busy;
    int          m_accepted;
    bit          m_out_valid;
    logic [HV-1:0] m_out [LN];
    int          m_batch;
    bit          m_done;
    logic [HV-1:0] m_bundle;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Bit j of the input lands at bit (j+amt) mod HV.
    function automatic logic [HV-1:0] rotate_ref(input logic [HV-1:0] v, input int amt);
        logic [HV-1:0] r;
        r = '0;
        for (int j = 0; j < HV; j++) begin
            r[(j + amt) % HV] = v[j];
        end
        return r;
    endfunction

    function automatic logic [HV-1:0] bundle_expected();
`ifdef ENC_BIND_BUNDLE_EN
        return m_bundle;
`else
        return '0;
`endif
    endfunction

    function automatic bit exp_in_ready(input bit ordy);
        return m_busy && (m_accepted < NB) && (!m_out_valid || ordy);
    endfunction

    task automatic model_reset();
        m_busy      = 1'b0;
        m_accepted  = 0;
        m_out_valid = 1'b0;
        m_batch     = 0;
        m_done      = 1'b0;
        m_bundle    = '0;
        for (int i = 0; i < LN; i++) m_out[i] = '0;
    endtask

    task automatic model_step(input bit st, input bit iv, input logic [HV-1:0] l0,
                              input logic [HV-1:0] l1, input bit ordy);
        logic [HV-1:0] lvl [LN];
        bit acc, cons, was_busy;
        lvl[0]   = l0;
        lvl[1]   = l1;
        acc      = iv && exp_in_ready(ordy);
        cons     = m_out_valid && ordy;
        was_busy = m_busy;
        m_done   = 1'b0;
        if (cons && (m_accepted == NB)) begin
            m_done = 1'b1;
            m_busy = 1'b0;
        end
        if (acc) begin
            for (int i = 0; i < LN; i++) begin
                m_out[i] = rotate_ref(lvl[i], shifts_ref[m_accepted*LN + i] % HV);
                m_bundle = m_bundle | m_out[i];
            end
            m_batch     = m_accepted;
            m_accepted  = m_accepted + 1;
            m_out_valid = 1'b1;
        end else if (cons) begin
            m_out_valid = 1'b0;
        end
        if (!was_busy && st) begin
            m_busy     = 1'b1;
            m_accepted = 0;
            m_bundle   = '0;
        end
    endtask

    task automatic compareAll();
        checkOutput("in_ready",  32'(bus.in_ready),  32'(exp_in_ready(bus.out_ready)));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
        checkOutput("busy",      32'(bus.busy),      32'(m_busy));
        checkOutput("done",      32'(bus.done),      32'(m_done));
        checkOutput("batch_idx", 32'(bus.batch_idx), 32'(m_batch));
        for (int i = 0; i < LN; i++) begin
            checkOutput($sformatf("shifted_hv%0d", i), 32'(bus.shifted_hv[i]), 32'(m_out[i]));
        end
        checkOutput("bundle_hv", 32'(bus.bundle_hv), 32'(bundle_expected()));
    endtask

    // Called just after a rising edge; drives one cycle, checks mid-cycle.
    task automatic applyStimulus(input bit st, input bit iv, input logic [HV-1:0] l0,
                                 input logic [HV-1:0] l1, input bit ordy);
        bus.start_encoding = st;
        bus.in_valid       = iv;
        bus.level_hv[0]    = l0;
        bus.level_hv[1]    = l1;
        bus.out_ready      = ordy;
        @(negedge clk);
        compareAll();
        @(posedge clk);
        model_step(st, iv, l0, l1, ordy);
        #1;
    endtask

    // Asserts reset between edges and checks outputs before any clock edge.
    task automatic doReset();
        nrst = 1'b0;
        #1;
        model_reset();
        compareAll();
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start_encoding = 1'b0;
        bus.in_valid       = 1'b0;
        bus.level_hv[0]    = '0;
        bus.level_hv[1]    = '0;
        bus.out_ready      = 1'b1;
        model_reset();
        #2;
        doReset();

        // Basic frame with out_ready held high
        $display("[TB] basic frame");
        applyStimulus(1, 0, 16'h0000, 16'h0000, 1);
        applyStimulus(0, 1, 16'h0001, 16'h8000, 1);
        checkOutput("basic_b0_l0", 32'(bus.shifted_hv[0]), 32'h0002);
        checkOutput("basic_b0_l1", 32'(bus.shifted_hv[1]), 32'h8000);
        applyStimulus(0, 1, 16'h0001, 16'h8000, 1);
        checkOutput("basic_b1_l0", 32'(bus.shifted_hv[0]), 32'h8000);
        checkOutput("basic_b1_l1", 32'(bus.shifted_hv[1]), 32'h8000);
        checkOutput("basic_b1_idx", 32'(bus.batch_idx), 32'd1);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1);
        checkOutput("basic_done", 32'(bus.done), 32'd1);
`ifdef ENC_BIND_BUNDLE_EN
        checkOutput("basic_bundle", 32'(bus.bundle_hv), 32'h8002);
`else
        checkOutput("basic_bundle", 32'(bus.bundle_hv), 32'h0000);
`endif
        applyStimulus(0, 1, 16'h1234, 16'h4321, 1);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1);

        // Backpressure for three cycles after the first output
        $display("[TB] backpressure");
        applyStimulus(1, 0, 16'h0000, 16'h0000, 1);
        applyStimulus(0, 1, 16'h00F1, 16'hA5A5, 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 16'h0F0F, 16'h3C3C, 0);
        checkOutput("bp_hold_l0", 32'(bus.shifted_hv[0]), 32'h01E2);
        applyStimulus(0, 1, 16'h0F0F, 16'h3C3C, 1);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1);

        // Second start mid-frame must not restart the frame
        $display("[TB] restart ignored");
        applyStimulus(1, 0, 16'h0000, 16'h0000, 1);
        applyStimulus(0, 1, 16'hC001, 16'h0002, 1);
        applyStimulus(1, 1, 16'h0003, 16'h7777, 1);
        checkOutput("restart_idx", 32'(bus.batch_idx), 32'd1);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1);
        applyStimulus(0, 0, 16'h0000, 16'h0000, 1);

        // Reset one cycle after the first accept
        $display("[TB] mid-frame reset");
        applyStimulus(1, 0, 16'h0000, 16'h0000, 1);
        applyStimulus(0, 1, 16'hBEEF, 16'hCAFE, 1);
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 16'h1111, 16'h2222, 1);

        // Randomized traffic
        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                          16'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/enc_binder_seq.md
ENC_BINDER_SEQ -- requirements
Module: enc_binder_seq

Interface
REQ-001 Parameter HV_DIM, default 1024: hypervector width in bits.
REQ-002 Parameter LANES, default 8: binders instantiated in parallel.
REQ-003 Parameter NUM_BATCHES, default 4: batches per frame; frame covers LANES*NUM_BATCHES features.
REQ-004 Parameter BASE_IDX, default 0: first index into the package SHIFTS table used by this instance.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 nrst  input  1  asynchronous, active-low reset.
REQ-007 start_encoding  input  1  one-cycle pulse that opens a frame.
REQ-008 in_valid  input  1  level_hv holds a valid batch.
REQ-009 in_ready  output  1  block accepts a batch this cycle.
REQ-010 level_hv  input  HV_DIM x LANES  unpacked array of level hypervectors, one per lane.
REQ-011 shifted_hv  output  HV_DIM x LANES  registered bound hypervectors.
REQ-012 out_valid  output  1  shifted_hv holds a valid batch.
REQ-013 out_ready  input  1  downstream consumes shifted_hv.
REQ-014 batch_idx  output  clog2(NUM_BATCHES) (min 1)  batch number of the current shifted_hv.
REQ-015 busy  output  1  frame in progress.
REQ-016 done  output  1  one-cycle pulse when the last batch of a frame is consumed.
REQ-017 bundle_hv  output  HV_DIM  frame bundle (see Configuration).

Function
REQ-018 States: IDLE, BIND, DRAIN; busy = 1 in BIND and DRAIN.
REQ-019 IDLE -> BIND on start_encoding; batch counter cleared to 0.
REQ-020 in_ready = 1 only in BIND, when out_valid == 0 or out_ready == 1.
REQ-021 Accept = in_valid && in_ready. On accept, lane i is registered to shifted_hv[i] as level_hv[i] rotated left by (SHIFTS[BASE_IDX + batch*LANES + i] mod HV_DIM). batch_idx is registered to batch, and out_valid is set one cycle later.
REQ-022 Latency: exactly 1 cycle from accept to out_valid.
REQ-023 shifted_hv and batch_idx stay stable while out_valid && !out_ready.
REQ-024 out_valid clears after out_ready, unless a new accept occurs in the same cycle. Accept and consume in one cycle give full throughput of one batch per cycle.
REQ-025 Batch counter increments on each accept. The accept of batch NUM_BATCHES-1 moves BIND -> DRAIN.
REQ-026 In DRAIN, the consume of the final batch pulses done, clears out_valid and moves to IDLE.
REQ-027 start_encoding is ignored while busy.
REQ-028 in_valid outside BIND is ignored; no state change.
REQ-029 A rotate amount of 0 or a multiple of HV_DIM passes level_hv unchanged.

Reset
REQ-030 nrst low asynchronously forces IDLE, clears the batch counter, and sets out_valid, done, busy, in_ready, batch_idx and bundle_hv to 0. shifted_hv resets to all-zero.
REQ-031 Reset mid-frame aborts the frame with no done pulse. The next frame requires a new start_encoding.

Configuration
REQ-032 Macro ENC_BIND_BUNDLE_EN defined: bundle_hv is OR-accumulated with all lanes of each accepted batch's bound vectors. bundle_hv clears on start_encoding and is valid and stable from the done pulse until the next start_encoding.
REQ-033 Macro ENC_BIND_BUNDLE_EN undefined: the port still exists and bundle_hv is constant 0; no accumulator register is built.

Verification
REQ-034 Setup: HV_DIM=16, LANES=2, NUM_BATCHES=2, BASE_IDX=0, SHIFTS[0..3]={1,0,15,16}; level_hv={16'h0001,16'h8000} both batches; out_ready=1 throughout. Response: batch 0 = {16'h0002,16'h8000}, batch 1 = {16'h8000,16'h8000}; done one cycle after batch 1 output.
REQ-035 Backpressure: out_ready=0 for 3 cycles after the first out_valid. Response: in_ready=0, shifted_hv unchanged, no batch lost; done only after the second consume.
REQ-036 start_encoding pulsed again mid-frame. Response: no counter clear; frame completes with exactly 2 outputs.
REQ-037 nrst asserted one cycle after the first accept. Response: all outputs 0 immediately, no done, state IDLE; in_valid then ignored until start_encoding.
REQ-038 With ENC_BIND_BUNDLE_EN, REQ-034 stimulus. Response: bundle_hv = 16'h8002 at done. Without the macro: bundle_hv = 0 always.
